key_mux_arb: RTL and testbench
==============================

Name: key_mux_arb

Overview:
- Parametrised N-channel valid/ready multiplexer. Successor to the combinational key-select mux.
- Arbitrates among NR_CH requesting input channels using fixed-priority or round-robin mode.
- The winner's data and channel index are captured into a one-entry output register.
- Sits between multiple producers (e.g. IFU/LSU memory requests) and one shared consumer (bus or memory port).

Parameters:
- NR_CH, 4, number of input channels (>=2).
- DATA_LEN, 64, payload width per channel.
- IDX_LEN, 2, width of channel index; must equal clog2(NR_CH).
- MODE, 0, arbitration policy: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  NR_CH  per-channel request valid; bit n = channel n.
- in_ready  output  NR_CH  per-channel accept; at most one bit high per cycle.
- in_data  input  NR_CH*DATA_LEN  packed payloads; channel n at [DATA_LEN*(n+1)-1 : DATA_LEN*n].
- out_valid  output  1  output register holds a valid item.
- out_ready  input  1  consumer accepts the item.
- out_data  output  DATA_LEN  registered payload.
- out_idx  output  IDX_LEN  channel index the payload came from.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_data=0, out_idx=0, round-robin pointer ptr=0.
  - Any held item is discarded.
  - in_ready is all-zero while rst is high.
- can_load = !out_valid | out_ready. The output register is empty or drains this cycle.
- Grant (combinational, one-hot or zero):
  - MODE=0: lowest n with in_valid[n]=1.
  - MODE=1: first n with in_valid[n]=1, searching ptr, ptr+1, ..., NR_CH-1, 0, ..., ptr-1 (wrap-around).
  - No request: grant=0.
- in_ready = grant & {NR_CH{can_load}}.
  - in_ready may depend on in_valid of other channels.
  - Producers must not make in_valid depend on in_ready.
- Transfer on channel g when in_valid[g] & in_ready[g]. At that edge:
  - out_data <= in_data slice g; out_idx <= g; out_valid <= 1.
- Output drain (out_valid & out_ready) with no simultaneous transfer: out_valid <= 0. out_data/out_idx hold their last values.
- Drain and transfer in the same cycle: the new item replaces the old one. Full throughput is 1 item/cycle.
- Backpressure: while out_valid=1 and out_ready=0, out_valid, out_data and out_idx are held stable, and in_ready=0.
- Latency: an input accepted at edge k is visible on out_* after edge k (1 cycle).
- Round-robin pointer (MODE=1 only):
  - On a transfer from g, ptr <= (g+1) mod NR_CH. Wrap from NR_CH-1 to 0.
  - ptr is unchanged when no transfer occurs, including cycles stalled by backpressure.
  - ptr is unused when MODE=0.
- Starvation: MODE=1 guarantees service within NR_CH transfers for a continuously valid channel. MODE=0 gives no guarantee.
- Producer rules: a producer holds in_valid/in_data stable until accepted. The block does not check this.
- Reset mid-operation: a pending item in the output register is lost, and ptr returns to 0.

Test Plan:
- Reset / idle. Assert rst 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0, out_idx=0. Then in_valid=0 -> out_valid stays 0.
- Fixed priority. MODE=0; in_valid=1010, ch1 data=0x11, ch3 data=0x33, out_ready=1 -> every cycle in_ready=0010, out_data=0x11, out_idx=1. ch3 is never granted.
- Round-robin with wrap-around. MODE=1; in_valid=1111, out_ready=1, ch n data=0xA0+n -> out_idx sequence 0,1,2,3,0,1; out_data 0xA0,0xA1,0xA2,0xA3,0xA0. A transfer occurs every cycle.
- Backpressure. Load ch2 data=0xDEAD, then out_ready=0 for 5 cycles with in_valid=0011 -> out_valid=1, out_data=0xDEAD, out_idx=2 stable; in_ready=0000. MODE=1: ptr stays 3. Then out_ready=1 -> next grant is ch0 (wrap from ptr=3).
- Simultaneous drain and load. out_valid=1 holding 0x55, out_ready=1, in_valid[1]=1 with data 0x66 -> in_ready=0010; next cycle out_valid=1, out_data=0x66, out_idx=1. No bubble.
- Reset mid-operation. MODE=1, ptr=2, out_valid=1, out_ready=0; pulse rst 1 cycle -> out_valid=0, out_data=0. Then in_valid=1111 -> first grant is ch0.

Source files
------------

// File: rtl/key_mux_arb.sv
// N-channel valid/ready multiplexer. It arbitrates by fixed priority or round-robin and
// captures the winner's payload and channel index in a one-entry output register.
module key_mux_arb #(
  parameter int unsigned NR_CH    = 4,
  parameter int unsigned DATA_LEN = 64,
  parameter int unsigned IDX_LEN  = 2,
  parameter int unsigned MODE     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NR_CH-1:0]          in_valid,
  output logic [NR_CH-1:0]          in_ready,
  input  logic [NR_CH*DATA_LEN-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_LEN-1:0]       out_data,
  output logic [IDX_LEN-1:0]        out_idx
);

  logic [IDX_LEN-1:0]  ptr_q, ptr_d;
  logic [NR_CH-1:0]    grant;
  logic [IDX_LEN-1:0]  grant_idx;
  logic [DATA_LEN-1:0] grant_data;
  logic                found;
  logic                can_load;
  logic                transfer;

  assign can_load = !out_valid || out_ready;

  // Search order starts at ptr in round-robin mode and at channel 0 in fixed-priority mode.
  always_comb begin
    int unsigned cand;
    grant      = '0;
    grant_idx  = '0;
    grant_data = '0;
    found      = 1'b0;
    cand       = 0;
    for (int unsigned k = 0; k < NR_CH; k++) begin
      cand = (MODE == 1) ? ((32'(ptr_q) + k) % NR_CH) : k;
      if (!found && in_valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_LEN'(cand);
        grant_data  = in_data[cand*DATA_LEN +: DATA_LEN];
      end
    end
  end

  assign in_ready = rst ? '0 : (grant & {NR_CH{can_load}});
  assign transfer = |(in_valid & in_ready);

  always_comb begin
    ptr_d = ptr_q;
    if (MODE == 1 && transfer) begin
      ptr_d = (32'(grant_idx) == NR_CH - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      ptr_q     <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (transfer) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_idx   <= grant_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_mux_arb.sv
// Self-checking bench: fixed-priority and round-robin instances share one stimulus stream,
// and each instance is compared against a behavioural model of the arbitration rules.
module tb_key_mux_arb;

  localparam int NCH = 4;
  localparam int DW  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    in_valid;
  logic [NCH*DW-1:0] in_data;
  logic              out_ready;

  logic [NCH-1:0] rdy_fp, rdy_rr;
  logic           ov_fp, ov_rr;
  logic [DW-1:0]  od_fp, od_rr;
  logic [1:0]     oi_fp, oi_rr;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state, indexed by mode (0 = fixed priority, 1 = round-robin).
  logic          mv[2];
  logic [DW-1:0] md[2];
  int            mi[2];
  int            mp[2];

  always #5 clk = ~clk;

  key_mux_arb #(.NR_CH(NCH), .DATA_LEN(DW), .IDX_LEN(2), .MODE(0)) u_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_fp), .in_data(in_data),
    .out_valid(ov_fp), .out_ready(out_ready), .out_data(od_fp), .out_idx(oi_fp)
  );

  key_mux_arb #(.NR_CH(NCH), .DATA_LEN(DW), .IDX_LEN(2), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_rr), .in_data(in_data),
    .out_valid(ov_rr), .out_ready(out_ready), .out_data(od_rr), .out_idx(oi_rr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winning channel under the given policy, or -1 when nobody requests.
  function automatic int pick(input int mode, input logic [NCH-1:0] v, input int ptr);
    int start;
    start = (mode == 1) ? ptr : 0;
    for (int k = 0; k < NCH; k++) begin
      if (v[(start + k) % NCH]) return (start + k) % NCH;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] slice(input int ch);
    return in_data[ch*DW +: DW];
  endfunction

  task automatic set_data(input int ch, input logic [DW-1:0] val);
    in_data[ch*DW +: DW] = val;
  endtask

  // One clock: check in_ready before the edge, advance the model, check outputs after it.
  task automatic step();
    int g;
    logic [NCH-1:0] exp_rdy;
    #1;
    for (int m = 0; m < 2; m++) begin
      g = pick(m, in_valid, mp[m]);
      exp_rdy = '0;
      if (!rst && g >= 0 && (!mv[m] || out_ready)) exp_rdy[g] = 1'b1;
      chk(m == 0 ? "fp_in_ready" : "rr_in_ready", m == 0 ? rdy_fp : rdy_rr, exp_rdy);
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      g = pick(m, in_valid, mp[m]);
      if (rst) begin
        mv[m] = 1'b0; md[m] = '0; mi[m] = 0; mp[m] = 0;
      end else if (g >= 0 && (!mv[m] || out_ready)) begin
        mv[m] = 1'b1; md[m] = slice(g); mi[m] = g;
        if (m == 1) mp[m] = (g + 1) % NCH;
      end else if (out_ready) begin
        mv[m] = 1'b0;
      end
    end
    #1;
    chk("fp_out_valid", ov_fp, mv[0]);
    chk("fp_out_data",  od_fp, md[0]);
    chk("fp_out_idx",   oi_fp, mi[0]);
    chk("rr_out_valid", ov_rr, mv[1]);
    chk("rr_out_data",  od_rr, md[1]);
    chk("rr_out_idx",   oi_rr, mi[1]);
    @(negedge clk);
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      mv[m] = 1'b0; md[m] = '0; mi[m] = 0; mp[m] = 0;
    end
    rst = 1'b1; in_valid = '1; in_data = '0; out_ready = 1'b0;
    @(negedge clk);

    // Reset with every channel requesting
    step();
    step();
    chk("rst_out_data", od_rr, 64'h0);
    rst = 1'b0; in_valid = '0;
    step();
    chk("idle_out_valid", ov_fp, 1'b0);

    // Fixed priority: ch1 always beats ch3
    in_valid = 4'b1010; set_data(1, 64'h11); set_data(3, 64'h33); out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fp_always_ch1", oi_fp, 2'd1);
    end

    // Round-robin with wrap-around, from a fresh pointer
    rst = 1'b1; step(); rst = 1'b0;
    in_valid = 4'b1111;
    for (int c = 0; c < NCH; c++) set_data(c, 64'hA0 + 64'(c));
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_seq", oi_rr, 64'(i % NCH));
    end

    // Backpressure: hold ch2 item while producers 0 and 1 wait
    in_valid = 4'b0100; set_data(2, 64'hDEAD);
    step();
    in_valid = 4'b0011; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_data", od_rr, 64'hDEAD);
    end
    out_ready = 1'b1;
    step();
    chk("bp_wrap_ch0", oi_rr, 2'd0);

    // Drain and load in the same cycle
    in_valid = 4'b0001; set_data(0, 64'h55);
    step();
    in_valid = 4'b0010; set_data(1, 64'h66);
    step();
    chk("no_bubble", od_fp, 64'h66);

    // Reset while an item is held and ptr is 2
    in_valid = 4'b0010;
    step();
    in_valid = 4'b0100; out_ready = 1'b0;
    step();
    rst = 1'b1; in_valid = '0;
    step();
    rst = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
    step();
    chk("post_rst_ch0", oi_rr, 2'd0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = NCH'($urandom);
      out_ready = ($urandom_range(3) != 0);
      rst       = ($urandom_range(60) == 0);
      for (int c = 0; c < NCH; c++) set_data(c, {$urandom, $urandom});
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
